// File: rtl/lsu_mem_access_pkg.sv
// Shared encodings and opcode predicates for the load/store unit.
// Opcodes 9..15 are undefined and behave as NOP.
package lsu_mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/lsu_mem_access_lane_align.sv
// Little-endian lane steering: byte enables, replicated store data, load extraction/extension
// and alignment check. Purely combinational.
module lsu_lane_align
    import lsu_mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_result,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be          = 4'b0000;
        wdata       = 32'h0;
        load_result = 32'h0;
        misaligned  = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be = 4'b0001 << addr_lo;
            end
            OP_LH, OP_LHU, OP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            OP_LW, OP_SW: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
        case (op)
            OP_LB:   load_result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_result = {24'h0, byte_sel};
            OP_LH:   load_result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_result = {16'h0, half_sel};
            OP_LW:   load_result = rdata;
            OP_SB:   wdata = {4{store_data[7:0]}};
            OP_SH:   wdata = {2{store_data[15:0]}};
            OP_SW:   wdata = store_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// MIPS32 load/store unit: non-memory ops in 1 cycle, memory ops 2 + wait cycles;
// stall_o holds upstream while a bus access is outstanding, with a bus timeout.
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_write_i,
    output logic        stall_o,
    output logic        out_valid,
    output logic [31:0] write_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_write_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        bus_err_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic [4:0]  rd_addr_q;
    logic        rd_write_q;

    logic        in_req;
    logic        is_mem;
    logic        accept;
    logic        finish;
    logic        timeout;

    logic [3:0]  al_op;
    logic [1:0]  al_addr;
    logic [31:0] al_sd;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misaligned;

    assign in_req = (state == ST_REQ);
    assign is_mem = is_load(mem_op) || is_store(mem_op);

    // In IDLE the aligner judges the incoming op; in REQ it steers the latched access.
    assign al_op   = in_req ? op_q        : mem_op;
    assign al_addr = in_req ? addr_q[1:0] : alu_result[1:0];
    assign al_sd   = in_req ? sd_q        : store_data;

    lsu_lane_align u_align (
        .op          (al_op),
        .addr_lo     (al_addr),
        .store_data  (al_sd),
        .rdata       (dmem_rdata),
        .be          (al_be),
        .wdata       (al_wdata),
        .load_result (al_load),
        .misaligned  (al_misaligned)
    );

    assign stall_o    = in_req;
    assign dmem_req   = in_req;
    assign dmem_we    = in_req && is_store(op_q);
    assign dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_be    = in_req ? al_be : 4'b0000;
    assign dmem_wdata = in_req ? al_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && is_mem && !al_misaligned) begin
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack in the final timeout cycle takes priority over the error.
                if (dmem_ack) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt      <= 8'h0;
            op_q         <= 4'h0;
            addr_q       <= 32'h0;
            sd_q         <= 32'h0;
            rd_addr_q    <= 5'h0;
            rd_write_q   <= 1'b0;
            out_valid    <= 1'b0;
            write_data_o <= 32'h0;
            rd_addr_o    <= 5'h0;
            rd_write_o   <= 1'b0;
            adel_o       <= 1'b0;
            ades_o       <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            adel_o    <= 1'b0;
            ades_o    <= 1'b0;
            bus_err_o <= 1'b0;
            if (accept) begin
                op_q       <= mem_op;
                addr_q     <= alu_result;
                sd_q       <= store_data;
                rd_addr_q  <= rd_addr_i;
                rd_write_q <= rd_write_i;
                tmo_cnt    <= 8'h0;
            end else if (!in_req && in_valid) begin
                // Non-memory op, or a misaligned access that never reaches the bus.
                out_valid    <= 1'b1;
                write_data_o <= alu_result;
                rd_addr_o    <= rd_addr_i;
                rd_write_o   <= rd_write_i && !is_mem;
                adel_o       <= is_load(mem_op);
                ades_o       <= is_store(mem_op);
            end else if (finish) begin
                out_valid    <= 1'b1;
                write_data_o <= is_load(op_q) ? al_load : 32'h0;
                rd_addr_o    <= rd_addr_q;
                rd_write_o   <= is_load(op_q) && rd_write_q;
            end else if (timeout) begin
                out_valid    <= 1'b1;
                write_data_o <= 32'h0;
                rd_addr_o    <= rd_addr_q;
                rd_write_o   <= 1'b0;
                bus_err_o    <= 1'b1;
            end else if (in_req) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Randomized bench for lsu_mem_access against a transaction-level model with a
// bench-driven memory responder (random wait states, timeouts, spurious acks).
module tb_lsu_mem_access;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr_i;
    logic        rd_write_i;
    logic        stall_o;
    logic        out_valid;
    logic [31:0] write_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_write_o;
    logic        adel_o;
    logic        ades_o;
    logic        bus_err_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    lsu_mem_access #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .mem_op       (mem_op),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_addr_i    (rd_addr_i),
        .rd_write_i   (rd_write_i),
        .stall_o      (stall_o),
        .out_valid    (out_valid),
        .write_data_o (write_data_o),
        .rd_addr_o    (rd_addr_o),
        .rd_write_o   (rd_write_o),
        .adel_o       (adel_o),
        .ades_o       (ades_o),
        .bus_err_o    (bus_err_o),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rdw;
        int          wait_n;
    } instr_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    instr_t dq[$];
    logic   dir_only = 1'b0;
    instr_t cur;
    logic   cur_used = 1'b1;
    instr_t acc;
    logic   acc_active = 1'b0;
    int     acc_age = 0;

    logic        e_vld = 1'b0;
    logic        e_data_chk = 1'b0;
    logic [31:0] e_data = 32'h0;
    logic [4:0]  e_rd = 5'h0;
    logic        e_rdw = 1'b0;
    logic        e_adel = 1'b0;
    logic        e_ades = 1'b0;
    logic        e_berr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic ref_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic ref_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // access size in bytes; 0 for non-memory ops
    function automatic int ref_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] a);
        int sz = ref_size(op);
        int lane = int'(a % 4);
        if (sz == 1) return 4'(1 << lane);
        if (sz == 2) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] sd);
        int sz = ref_size(op);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load_val(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        case (op)
            4'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            4'd2: v = v & 32'hFF;
            4'd3: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            4'd4: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [4:0] rd, input logic rdw, input int wn,
                                  input logic [31:0] rdata);
        instr_t t;
        t.vld = 1'b1; t.op = op; t.alu = alu; t.sd = sd;
        t.rd = rd; t.rdw = rdw; t.wait_n = wn; t.rdata = rdata;
        return t;
    endfunction

    function automatic instr_t next_instr();
        instr_t t;
        if (dq.size() > 0) return dq.pop_front();
        t = mk(4'($urandom_range(0, 11)), $urandom, $urandom, 5'($urandom), 1'($urandom), 0, $urandom);
        t.vld = !dir_only && ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 1) == 1) t.alu[1:0] = 2'b00;
        t.wait_n = $urandom_range(0, 9);
        if (t.wait_n > TMO - 1) t.wait_n = 99;
        return t;
    endfunction

    task automatic step();
        logic ack;
        logic mis;
        @(negedge clk);
        cyc++;
        chk("out_valid", 32'(out_valid), 32'(e_vld));
        if (e_vld) begin
            if (e_data_chk) chk("write_data", write_data_o, e_data);
            chk("rd_addr", 32'(rd_addr_o), 32'(e_rd));
            chk("rd_write", 32'(rd_write_o), 32'(e_rdw));
        end
        chk("adel", 32'(adel_o), 32'(e_adel));
        chk("ades", 32'(ades_o), 32'(e_ades));
        chk("bus_err", 32'(bus_err_o), 32'(e_berr));
        chk("stall", 32'(stall_o), 32'(acc_active));
        chk("dmem_req", 32'(dmem_req), 32'(acc_active));
        if (acc_active) begin
            chk("dmem_addr", dmem_addr, acc.alu & 32'hFFFF_FFFC);
            chk("dmem_be", 32'(dmem_be), 32'(ref_be(acc.op, acc.alu)));
            chk("dmem_we", 32'(dmem_we), 32'(ref_store(acc.op)));
            if (ref_store(acc.op)) chk("dmem_wdata", dmem_wdata, ref_wdata(acc.op, acc.sd));
        end

        e_vld = 1'b0; e_data_chk = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_berr = 1'b0;
        if (cur_used) begin
            cur = next_instr();
            cur_used = 1'b0;
        end
        in_valid   = cur.vld;
        mem_op     = cur.op;
        alu_result = cur.alu;
        store_data = cur.sd;
        rd_addr_i  = cur.rd;
        rd_write_i = cur.rdw;

        if (acc_active) begin
            ack = (acc_age == acc.wait_n);
            dmem_ack   = ack;
            dmem_rdata = ack ? acc.rdata : $urandom;
            if (ack || acc_age == TMO - 1) begin
                e_vld = 1'b1;
                e_rd  = acc.rd;
                e_rdw = ack && ref_load(acc.op) && acc.rdw;
                e_berr = !ack;
                e_data_chk = ack;
                e_data = ref_load(acc.op) ? ref_load_val(acc.op, acc.alu, acc.rdata) : 32'h0;
                acc_active = 1'b0;
            end else begin
                acc_age++;
            end
        end else begin
            // idle: stray acks must be ignored
            dmem_ack   = !cur.vld || ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            cur_used   = 1'b1;
            if (cur.vld) begin
                mis = (ref_size(cur.op) == 2 && cur.alu % 2 != 0) ||
                      (ref_size(cur.op) == 4 && cur.alu % 4 != 0);
                if (ref_size(cur.op) == 0) begin
                    e_vld = 1'b1; e_data_chk = 1'b1; e_data = cur.alu;
                    e_rd = cur.rd; e_rdw = cur.rdw;
                end else if (mis) begin
                    e_vld = 1'b1; e_rd = cur.rd; e_rdw = 1'b0;
                    e_adel = ref_load(cur.op);
                    e_ades = ref_store(cur.op);
                end else begin
                    acc = cur;
                    acc_active = 1'b1;
                    acc_age = 0;
                end
            end
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1; in_valid = 1'b0; mem_op = 4'h0; alu_result = 32'h0; store_data = 32'h0;
        rd_addr_i = 5'h0; rd_write_i = 1'b0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_write_data", write_data_o, 32'h0);
        chk("rst_flags", {28'h0, rd_write_o, adel_o, ades_o, bus_err_o}, 32'h0);
        chk("rst_dmem_be", 32'(dmem_be), 32'h0);
        rst = 1'b0;

        dq.push_back(mk(4'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 32'h0));
        dq.push_back(mk(4'd1, 32'h0000_1003, 32'h0, 5'd3, 1'b1, 3, 32'h80FF_1122));
        dq.push_back(mk(4'd2, 32'h0000_1003, 32'h0, 5'd4, 1'b1, 3, 32'h80FF_1122));
        dq.push_back(mk(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 5'd6, 1'b1, 1, 32'h0));
        dq.push_back(mk(4'd5, 32'h0000_3001, 32'h0, 5'd8, 1'b1, 0, 32'h0));
        dq.push_back(mk(4'd8, 32'h0000_3002, 32'h5555_AAAA, 5'd9, 1'b1, 0, 32'h0));
        dq.push_back(mk(4'd5, 32'h0000_4000, 32'h0, 5'd10, 1'b1, 99, 32'h0));
        begin
            instr_t idle_t = mk(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0);
            idle_t.vld = 1'b0;
            repeat (3) dq.push_back(idle_t);
        end
        repeat (3000) step();

        // reset during the second REQ cycle of a load
        dir_only = 1'b1;
        dq.push_back(mk(4'd5, 32'h0000_5000, 32'h0, 5'd11, 1'b1, 99, 32'h0));
        guard = 0;
        while (!(acc_active && acc.alu == 32'h0000_5000 && acc_age == 1) && guard < 200) begin
            step();
            guard++;
        end
        chk("reach_req_for_reset", 32'(guard < 200), 32'h1);
        @(negedge clk);
        cyc++;
        rst = 1'b1; in_valid = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        cyc++;
        chk("abort_dmem_req", 32'(dmem_req), 32'h0);
        chk("abort_stall", 32'(stall_o), 32'h0);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        acc_active = 1'b0; cur_used = 1'b1;
        e_vld = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_berr = 1'b0;

        // load followed by an ALU op held under stall
        dq.push_back(mk(4'd5, 32'h0000_6000, 32'h0, 5'd12, 1'b1, 2, 32'hDEAD_BEEF));
        dq.push_back(mk(4'd0, 32'h0000_CAFE, 32'h0, 5'd13, 1'b1, 0, 32'h0));
        repeat (20) step();
        chk("directed_drained", 32'(dq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
